i2s_tx_fifo: RTL and testbench

Parametrised I2S (Philips format) serial audio transmitter with an internal stereo sample FIFO and a valid/ready input handshake. It generates bit_clk and frame_clk from the system clock through a programmable divider and shifts each left/right sample out MSB-first with the standard one-bit delay. The slot width is runtime-selectable per frame. The block sits between the synth voice/mixer output and the DAC pins. It replaces fixed-width, single-sample I2S transmission with buffered, back-pressured operation and underrun reporting.

---
 rtl/i2s_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_i2s_tx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: Philips-format I2S transmitter with a stereo sample FIFO.
// A divider derives bit_clk from clk. Each bit_clk fall advances the frame
// position or starts a new frame. A new frame pops one L/R pair, or loads
// zeros and pulses underrun when the FIFO is empty. The slot width is
// latched once per frame.
module i2s_tx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        word_length,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_clk,
  output logic              frame_clk,
  output logic              data,
  output logic              underrun,
  output logic [7:0]        fifo_level,
  output logic [7:0]        frame_pos
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]       DATA_W_C = 8'(DATA_W);

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic              idle_q, idle_d;
  logic [7:0]        p_q, p_d, w_q, w_d;
  logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
  logic              data_q, data_d, ws_q, ws_d, ur_q, ur_d;

  logic              push, pop, fall, frame_start;
  logic [8:0]        cur_bits, cur_last, new_bits, next_pos;
  logic [7:0]        w_sel;
  logic [DATA_W-1:0] shifted;

  // Next-state logic: divider, FIFO bookkeeping and frame sequencing
  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    idle_d   = idle_q;
    p_d      = p_q;
    w_d      = w_q;
    left_d   = left_q;
    right_d  = right_q;
    data_d   = data_q;
    ws_d     = ws_q;
    ur_d     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fall     = 1'b0;
    shifted  = '0;
    new_bits = '0;
    next_pos = '0;

    cur_bits = {w_q, 1'b0};
    cur_last = cur_bits - 9'd1;
    w_sel    = (word_length == 8'd0 || word_length > DATA_W_C) ? DATA_W_C : word_length;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    frame_start = fall && (idle_q || ({1'b0, p_q} == cur_last));
    // A full FIFO never accepts, even when a pop happens on the same edge.
    push        = in_valid && (count_q < DEPTH_C);
    pop         = frame_start && (count_q != '0);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (fall) begin
      if (frame_start) begin
        w_d    = w_sel;
        p_d    = 8'd0;
        idle_d = 1'b0;
        if (pop) begin
          left_d   = mem_l[rd_ptr_q];
          right_d  = mem_r[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          left_d  = '0;
          right_d = '0;
          ur_d    = 1'b1;
        end
      end else begin
        p_d = p_q + 8'd1;
      end

      // Word select leads the data by one bit: it reflects position p+1.
      new_bits = {w_d, 1'b0};
      next_pos = {1'b0, p_d} + 9'd1;
      if (next_pos == new_bits) begin
        next_pos = '0;
      end
      ws_d = (next_pos >= {1'b0, w_d});

      if (p_d < w_d) begin
        shifted = left_d >> (w_d - 8'd1 - p_d);
      end else begin
        shifted = right_d >> (new_bits - 9'd1 - {1'b0, p_d});
      end
      data_d = shifted[0];
    end
  end

  // Sample storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr_q] <= in_left;
      mem_r[wr_ptr_q] <= in_right;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      idle_q   <= 1'b1;
      p_q      <= 8'd0;
      w_q      <= DATA_W_C;
      left_q   <= '0;
      right_q  <= '0;
      data_q   <= 1'b0;
      ws_q     <= 1'b0;
      ur_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      idle_q   <= idle_d;
      p_q      <= p_d;
      w_q      <= w_d;
      left_q   <= left_d;
      right_q  <= right_d;
      data_q   <= data_d;
      ws_q     <= ws_d;
      ur_q     <= ur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign in_ready   = (count_q < DEPTH_C);
  assign bit_clk    = bclk_q;
  assign frame_clk  = ws_q;
  assign data       = data_q;
  assign underrun   = ur_q;
  assign fifo_level = 8'(count_q);
  assign frame_pos  = p_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed test of i2s_tx_fifo with CLK_DIV=1 and CLK_DIV=3
// instances sharing one set of inputs.
module tb_i2s_tx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    word_length;
  logic [DW-1:0] in_left, in_right;
  logic          in_valid;

  logic          rdy1, bclk1, ws1, dat1, ur1;
  logic [7:0]    lvl1, pos1;
  logic          rdy3, bclk3, ws3, dat3, ur3;
  logic [7:0]    lvl3, pos3;

  int checks = 0;
  int errors = 0;

  i2s_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .word_length(word_length),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(rdy1), .bit_clk(bclk1), .frame_clk(ws1), .data(dat1),
    .underrun(ur1), .fifo_level(lvl1), .frame_pos(pos1)
  );

  i2s_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .word_length(word_length),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(rdy3), .bit_clk(bclk3), .frame_clk(ws3), .data(dat3),
    .underrun(ur3), .fifo_level(lvl3), .frame_pos(pos3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period of the CLK_DIV=1 instance
  task automatic fall();
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  seq8;
    logic [7:0]  ws8;
    logic [15:0] seq16;
    logic [3:0]  seq4;
    int          k;

    in_valid = 1'b0; in_left = '0; in_right = '0; word_length = 8'd4;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_bit_clk", bclk1, 0);
    chk("rst_frame_clk", ws1, 0);
    chk("rst_data", dat1, 0);
    chk("rst_underrun", ur1, 0);
    chk("rst_level", lvl1, 0);
    chk("rst_pos", pos1, 0);
    chk("rst_ready", rdy1, 1);

    // Basic frame: W=4, L=7, R=13
    in_valid = 1'b1; in_left = 16'd7; in_right = 16'd13;
    tick();
    in_valid = 1'b0;
    chk("basic_push_level", lvl1, 1);
    chk("basic_first_rise", bclk1, 1);
    tick();
    chk("basic_pop_level", lvl1, 0);
    seq8 = 8'b01111101;
    ws8  = 8'b00011110;
    for (int p = 0; p < 8; p++) begin
      if (p > 0) fall();
      chk("basic_pos", pos1, 64'(p));
      chk("basic_data", dat1, seq8[7-p]);
      chk("basic_ws", ws1, ws8[7-p]);
      chk("basic_underrun", ur1, 0);
    end

    // Underrun frame, with a pair pushed mid-frame at p=3
    fall();
    chk("ur_pulse", ur1, 1);
    chk("ur_data", dat1, 0);
    chk("ur_pos", pos1, 0);
    tick();
    chk("ur_one_clk", ur1, 0);
    tick();
    for (int p = 1; p < 8; p++) begin
      chk("ur_frame_pos", pos1, 64'(p));
      chk("ur_frame_data", dat1, 0);
      if (p < 7) begin
        if (p == 3) begin
          in_valid = 1'b1; in_left = 16'h000A; in_right = 16'h0005;
        end
        tick();
        in_valid = 1'b0;
        if (p == 3) chk("ur_midpush_level", lvl1, 1);
        tick();
      end
    end

    // Frame with the mid-frame pair; word_length -> 8 at p=2 plus another push
    fall();
    seq8 = 8'b10100101;
    for (int p = 0; p < 8; p++) begin
      chk("f3_pos", pos1, 64'(p));
      chk("f3_data", dat1, seq8[7-p]);
      chk("f3_underrun", ur1, 0);
      if (p < 7) begin
        if (p == 2) begin
          word_length = 8'd8;
          in_valid = 1'b1; in_left = 16'h0081; in_right = 16'h003C;
        end
        tick();
        in_valid = 1'b0;
        tick();
      end
    end

    // Next frame is 16 bits long (W=8); word_length -> 0 at p=3
    fall();
    chk("w8_start_pos", pos1, 0);
    chk("w8_underrun", ur1, 0);
    chk("w8_level", lvl1, 0);
    seq16 = 16'b1000000100111100;
    for (int p = 0; p < 16; p++) begin
      if (p > 0) fall();
      if (p == 3) word_length = 8'd0;
      chk("w8_pos", pos1, 64'(p));
      chk("w8_data", dat1, seq16[15-p]);
      chk("w8_ws", ws1, (p >= 7 && p <= 14) ? 1 : 0);
    end

    // 32-bit frame from word_length=0; back-pressure while it runs
    fall();
    chk("w16_start_pos", pos1, 0);
    chk("w16_underrun", ur1, 1);
    in_valid = 1'b1; in_left = 16'h8000; in_right = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("bp_level", lvl1, 64'(i));
    end
    chk("bp_ready_low", rdy1, 0);
    tick();
    tick();
    chk("bp_level_held", lvl1, 4);
    chk("bp_pos3", pos1, 3);
    for (int p = 4; p < 32; p++) begin
      fall();
      if (p == 15) chk("w16_ws_p15", ws1, 1);
      if (p == 31) chk("w16_ws_p31", ws1, 0);
    end
    chk("w16_last_pos", pos1, 31);
    fall();
    chk("bp_pop_pos", pos1, 0);
    chk("bp_pop_level", lvl1, 3);
    chk("bp_pop_ready", rdy1, 1);
    chk("bp_pop_data", dat1, 1);
    chk("bp_pop_underrun", ur1, 0);
    tick();
    chk("bp_refill_level", lvl1, 4);
    in_valid = 1'b0;

    // Reset mid-frame at p=5 with two pairs queued
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_left = 16'hFFFF; in_right = 16'hFFFF;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mr_pre_pos", pos1, 5);
    chk("mr_pre_level", lvl1, 2);
    chk("mr_pre_data", dat1, 1);
    reset = 1'b1;
    #2;
    chk("mr_async_pos", pos1, 0);
    chk("mr_async_level", lvl1, 0);
    chk("mr_async_data", dat1, 0);
    chk("mr_async_bclk", bclk1, 0);
    chk("mr_async_ws", ws1, 0);
    tick();
    reset = 1'b0;
    chk("mr_rel_ready", rdy1, 1);
    tick();
    chk("mr_rise", bclk1, 1);
    chk("mr_no_early_frame", ur1, 0);
    tick();
    chk("mr_empty_underrun", ur1, 1);
    chk("mr_start_pos", pos1, 0);
    chk("mr_start_data", dat1, 0);

    // Divider: CLK_DIV=3 instance, W=2, L=2'b10, R=2'b01
    reset = 1'b1;
    tick();
    word_length = 8'd2; in_left = 16'h0002; in_right = 16'h0001;
    reset = 1'b0;
    chk("div_rst_bclk", bclk3, 0);
    chk("div_rst_data", dat3, 0);
    in_valid = 1'b1;
    seq4 = 4'b1001;
    for (int n = 1; n < 30; n++) begin
      tick();
      in_valid = 1'b0;
      k = (n - 6) / 6;
      chk("div_bclk", bclk3, 64'((n / 3) % 2));
      chk("div_data", dat3, (n < 6) ? 1'b0 : seq4[3-k]);
      chk("div_underrun", ur3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
